// File: rtl/argmax_topk_unit.sv
// ---------------------------------------------------------------------------
// argmax_topk_unit
//
// Sequential top-2 classifier head. A NUM_CLASSES x DATA_W score vector is
// captured in one handshake and scanned one element per cycle. The unit
// reports the best and runner-up class, their scores, the winning margin and
// a low-confidence flag against a threshold captured with the vector.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active high
//   in_valid      in   score vector present on scores
//   in_ready      out  unit can accept a vector (only while idle)
//   scores        in   class k at [k*DATA_W +: DATA_W]
//   conf_thresh   in   margin threshold, captured together with scores
//   out_valid     out  result registers valid
//   out_ready     in   consumer accepts the result
//   best_idx      out  index of the maximum score
//   best_score    out  maximum score
//   second_idx    out  index of the runner-up
//   second_score  out  runner-up score
//   margin        out  best_score - second_score, DATA_W+1 bits, never negative
//   low_conf      out  margin < conf_thresh (unsigned)
//   result_count  out  number of completed output handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module argmax_topk_unit #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4,
    parameter int SIGNED_MODE = 0,
    parameter int TIE_LOWEST  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CLASSES*DATA_W-1:0] scores,
    input  logic [DATA_W:0]               conf_thresh,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              best_idx,
    output logic [DATA_W-1:0]             best_score,
    output logic [IDX_W-1:0]              second_idx,
    output logic [DATA_W-1:0]             second_score,
    output logic [DATA_W:0]               margin,
    output logic                          low_conf,
    output logic [15:0]                   result_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_CLASSES - 1);

    // Widen a score to DATA_W+1 bits so that one signed compare/subtract
    // serves both the unsigned and the two's complement interpretation.
    function automatic logic [DATA_W:0] ext_score(input logic [DATA_W-1:0] v);
        if (SIGNED_MODE != 0) begin
            return {v[DATA_W-1], v};
        end else begin
            return {1'b0, v};
        end
    endfunction

    // True when candidate a displaces incumbent b under the tie rule.
    // A later element wins ties with >=, an earlier one keeps them with >.
    function automatic logic beats(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] ea;
        logic signed [DATA_W:0] eb;
        ea = $signed(ext_score(a));
        eb = $signed(ext_score(b));
        if (TIE_LOWEST != 0) begin
            return ea > eb;
        end else begin
            return ea >= eb;
        end
    endfunction

    // FSM and datapath state
    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                ptr_q, ptr_d;
    logic [NUM_CLASSES*DATA_W-1:0]   vec_q, vec_d;
    logic [DATA_W:0]                 thr_q, thr_d;
    logic [IDX_W-1:0]                run_best_idx_q, run_best_idx_d;
    logic [DATA_W-1:0]               run_best_score_q, run_best_score_d;
    logic [IDX_W-1:0]                run_sec_idx_q, run_sec_idx_d;
    logic [DATA_W-1:0]               run_sec_score_q, run_sec_score_d;
    logic                            sec_vld_q, sec_vld_d;

    // Output registers
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;
    logic [IDX_W-1:0]                best_idx_q, best_idx_d;
    logic [DATA_W-1:0]               best_score_q, best_score_d;
    logic [IDX_W-1:0]                second_idx_q, second_idx_d;
    logic [DATA_W-1:0]               second_score_q, second_score_d;
    logic [DATA_W:0]                 margin_q, margin_d;
    logic                            low_conf_q, low_conf_d;
    logic [15:0]                     result_count_q, result_count_d;

    logic [DATA_W-1:0]               elem_s;
    logic [DATA_W:0]                 margin_s;

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            ptr_q            <= {IDX_W{1'b0}};
            vec_q            <= '0;
            thr_q            <= '0;
            run_best_idx_q   <= {IDX_W{1'b0}};
            run_best_score_q <= {DATA_W{1'b0}};
            run_sec_idx_q    <= {IDX_W{1'b0}};
            run_sec_score_q  <= {DATA_W{1'b0}};
            sec_vld_q        <= 1'b0;
            in_ready_q       <= 1'b1;
            out_valid_q      <= 1'b0;
            best_idx_q       <= {IDX_W{1'b0}};
            best_score_q     <= {DATA_W{1'b0}};
            second_idx_q     <= {IDX_W{1'b0}};
            second_score_q   <= {DATA_W{1'b0}};
            margin_q         <= '0;
            low_conf_q       <= 1'b0;
            result_count_q   <= 16'd0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            vec_q            <= vec_d;
            thr_q            <= thr_d;
            run_best_idx_q   <= run_best_idx_d;
            run_best_score_q <= run_best_score_d;
            run_sec_idx_q    <= run_sec_idx_d;
            run_sec_score_q  <= run_sec_score_d;
            sec_vld_q        <= sec_vld_d;
            in_ready_q       <= in_ready_d;
            out_valid_q      <= out_valid_d;
            best_idx_q       <= best_idx_d;
            best_score_q     <= best_score_d;
            second_idx_q     <= second_idx_d;
            second_score_q   <= second_score_d;
            margin_q         <= margin_d;
            low_conf_q       <= low_conf_d;
            result_count_q   <= result_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture of the vector and the one-element-per-cycle top-2 scan
    always_comb begin
        vec_d            = vec_q;
        thr_d            = thr_q;
        ptr_d            = ptr_q;
        run_best_idx_d   = run_best_idx_q;
        run_best_score_d = run_best_score_q;
        run_sec_idx_d    = run_sec_idx_q;
        run_sec_score_d  = run_sec_score_q;
        sec_vld_d        = sec_vld_q;
        elem_s           = vec_q[int'(ptr_q) * DATA_W +: DATA_W];
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    vec_d = scores;
                    thr_d = conf_thresh;
                    ptr_d = {IDX_W{1'b0}};
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_SCAN: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == {IDX_W{1'b0}}) begin
                    // First element seeds best; second is still empty.
                    run_best_idx_d   = {IDX_W{1'b0}};
                    run_best_score_d = elem_s;
                    sec_vld_d        = 1'b0;
                end else if (beats(elem_s, run_best_score_q)) begin
                    // Old best drops to runner-up.
                    run_sec_idx_d    = run_best_idx_q;
                    run_sec_score_d  = run_best_score_q;
                    sec_vld_d        = 1'b1;
                    run_best_idx_d   = ptr_q;
                    run_best_score_d = elem_s;
                end else if (!sec_vld_q || beats(elem_s, run_sec_score_q)) begin
                    run_sec_idx_d    = ptr_q;
                    run_sec_score_d  = elem_s;
                    sec_vld_d        = 1'b1;
                end else begin
                    sec_vld_d        = sec_vld_q;
                end
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Margin of the finished scan; best never ranks below second, so the
    // DATA_W+1-bit difference is never negative.
    always_comb begin
        margin_s = ext_score(run_best_score_q) - ext_score(run_sec_score_q);
    end

    // Output register updates: result load on the first DONE cycle, release
    // on the output handshake, ready only while idle.
    always_comb begin
        in_ready_d     = (state_d == ST_IDLE);
        out_valid_d    = out_valid_q;
        best_idx_d     = best_idx_q;
        best_score_d   = best_score_q;
        second_idx_d   = second_idx_q;
        second_score_d = second_score_q;
        margin_d       = margin_q;
        low_conf_d     = low_conf_q;
        result_count_d = result_count_q;
        case (state_q)
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d    = 1'b1;
                    best_idx_d     = run_best_idx_q;
                    best_score_d   = run_best_score_q;
                    second_idx_d   = run_sec_idx_q;
                    second_score_d = run_sec_score_q;
                    margin_d       = margin_s;
                    low_conf_d     = (margin_s < thr_q);
                end else if (out_ready) begin
                    out_valid_d    = 1'b0;
                    result_count_d = result_count_q + 16'd1;
                end else begin
                    out_valid_d    = 1'b1;
                end
            end
            default: begin
                out_valid_d = out_valid_q;
            end
        endcase
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign best_idx     = best_idx_q;
    assign best_score   = best_score_q;
    assign second_idx   = second_idx_q;
    assign second_score = second_score_q;
    assign margin       = margin_q;
    assign low_conf     = low_conf_q;
    assign result_count = result_count_q;

endmodule

// File: tb/tb_argmax_topk_unit.sv
// ---------------------------------------------------------------------------
// tb_argmax_topk_unit
//
// Four instances share the control inputs:
//   0: 10 classes, unsigned, higher index wins ties
//   1: 10 classes, unsigned, lower index wins ties
//   2: 10 classes, signed,   higher index wins ties
//   3:  5 classes, unsigned, lower index wins ties (low 5 scores)
// A behavioural model (top-2 by value with index tie-break, fixed latency)
// is checked against every instance on each falling edge; directed vectors
// additionally pin hand-computed results.
// ---------------------------------------------------------------------------
module tb_argmax_topk_unit;

    typedef struct packed {
        logic [3:0]  bi;
        logic [15:0] bs;
        logic [3:0]  si;
        logic [15:0] ss;
        logic [16:0] mg;
        logic        lc;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [159:0] scores;
    logic [16:0]  conf_thresh;

    logic         o_ir  [4];
    logic         o_ov  [4];
    logic [3:0]   o_bi  [4];
    logic [15:0]  o_bs  [4];
    logic [3:0]   o_si  [4];
    logic [15:0]  o_ss  [4];
    logic [16:0]  o_mg  [4];
    logic         o_lc  [4];
    logic [15:0]  o_cnt [4];
    logic [2:0]   bi_d3;
    logic [2:0]   si_d3;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int lat;

    assign o_bi[3] = {1'b0, bi_d3};
    assign o_si[3] = {1'b0, si_d3};

    argmax_topk_unit #(.NUM_CLASSES(10), .DATA_W(16), .IDX_W(4), .SIGNED_MODE(0), .TIE_LOWEST(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[0]), .scores(scores),
        .conf_thresh(conf_thresh), .out_valid(o_ov[0]), .out_ready(out_ready),
        .best_idx(o_bi[0]), .best_score(o_bs[0]), .second_idx(o_si[0]), .second_score(o_ss[0]),
        .margin(o_mg[0]), .low_conf(o_lc[0]), .result_count(o_cnt[0]));

    argmax_topk_unit #(.NUM_CLASSES(10), .DATA_W(16), .IDX_W(4), .SIGNED_MODE(0), .TIE_LOWEST(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[1]), .scores(scores),
        .conf_thresh(conf_thresh), .out_valid(o_ov[1]), .out_ready(out_ready),
        .best_idx(o_bi[1]), .best_score(o_bs[1]), .second_idx(o_si[1]), .second_score(o_ss[1]),
        .margin(o_mg[1]), .low_conf(o_lc[1]), .result_count(o_cnt[1]));

    argmax_topk_unit #(.NUM_CLASSES(10), .DATA_W(16), .IDX_W(4), .SIGNED_MODE(1), .TIE_LOWEST(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[2]), .scores(scores),
        .conf_thresh(conf_thresh), .out_valid(o_ov[2]), .out_ready(out_ready),
        .best_idx(o_bi[2]), .best_score(o_bs[2]), .second_idx(o_si[2]), .second_score(o_ss[2]),
        .margin(o_mg[2]), .low_conf(o_lc[2]), .result_count(o_cnt[2]));

    argmax_topk_unit #(.NUM_CLASSES(5), .DATA_W(16), .IDX_W(3), .SIGNED_MODE(0), .TIE_LOWEST(1)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[3]), .scores(scores[79:0]),
        .conf_thresh(conf_thresh), .out_valid(o_ov[3]), .out_ready(out_ready),
        .best_idx(bi_d3), .best_score(o_bs[3]), .second_idx(si_d3), .second_score(o_ss[3]),
        .margin(o_mg[3]), .low_conf(o_lc[3]), .result_count(o_cnt[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- comparison helper ----------------
    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int n_of(input int d);
        return (d == 3) ? 5 : 10;
    endfunction

    function automatic bit tie_low_of(input int d);
        return (d == 1) || (d == 3);
    endfunction

    // i ranks above j: larger value, or equal value with the preferred index
    function automatic bit ranks_above(input int vi, input int i, input int vj, input int j, input bit tl);
        if (vi != vj) return vi > vj;
        return tl ? (i < j) : (i > j);
    endfunction

    function automatic res_t model(input int d, input logic [159:0] v, input logic [16:0] th);
        int   n;
        bit   tl;
        bit   sg;
        int   val [10];
        int   b;
        int   s;
        int   diff;
        res_t r;
        n  = n_of(d);
        tl = tie_low_of(d);
        sg = (d == 2);
        for (int i = 0; i < 10; i++) begin
            val[i] = sg ? int'($signed(v[i*16 +: 16])) : int'(v[i*16 +: 16]);
        end
        b = 0;
        for (int i = 1; i < n; i++) begin
            if (ranks_above(val[i], i, val[b], b, tl)) b = i;
        end
        s = (b == 0) ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            if (i != b && ranks_above(val[i], i, val[s], s, tl)) s = i;
        end
        diff = val[b] - val[s];
        r.bi = 4'(b);
        r.bs = v[b*16 +: 16];
        r.si = 4'(s);
        r.ss = v[s*16 +: 16];
        r.mg = 17'(diff);
        r.lc = (17'(diff) < th);
        return r;
    endfunction

    logic  m_live;
    logic  m_busy [4];
    logic  m_ov   [4];
    int    m_wait [4];
    int    m_cnt  [4];
    res_t  p_res  [4];
    res_t  e_res  [4];

    initial m_live = 1'b0;

    // Model update: capture when idle, result after NUM_CLASSES+1 cycles,
    // release on out_ready.
    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                m_busy[d] <= 1'b0;
                m_ov[d]   <= 1'b0;
                m_wait[d] <= 0;
                m_cnt[d]  <= 0;
                e_res[d]  <= '0;
                p_res[d]  <= '0;
            end else if (!m_busy[d]) begin
                if (in_valid) begin
                    m_busy[d] <= 1'b1;
                    m_wait[d] <= n_of(d) + 1;
                    p_res[d]  <= model(d, scores, conf_thresh);
                end
            end else if (!m_ov[d]) begin
                if (m_wait[d] == 1) begin
                    m_ov[d]  <= 1'b1;
                    e_res[d] <= p_res[d];
                end
                m_wait[d] <= m_wait[d] - 1;
            end else if (out_ready) begin
                m_ov[d]   <= 1'b0;
                m_busy[d] <= 1'b0;
                m_cnt[d]  <= m_cnt[d] + 1;
            end
        end
        if (rst) m_live <= 1'b1;
    end

    // Compare every instance against the model on each falling edge
    always @(negedge clk) begin
        if (m_live) begin
            for (int d = 0; d < 4; d++) begin
                chk("in_ready",     d, 32'(o_ir[d]),  32'(!m_busy[d]));
                chk("out_valid",    d, 32'(o_ov[d]),  32'(m_ov[d]));
                chk("best_idx",     d, 32'(o_bi[d]),  32'(e_res[d].bi));
                chk("best_score",   d, 32'(o_bs[d]),  32'(e_res[d].bs));
                chk("second_idx",   d, 32'(o_si[d]),  32'(e_res[d].si));
                chk("second_score", d, 32'(o_ss[d]),  32'(e_res[d].ss));
                chk("margin",       d, 32'(o_mg[d]),  32'(e_res[d].mg));
                chk("low_conf",     d, 32'(o_lc[d]),  32'(e_res[d].lc));
                chk("result_count", d, 32'(o_cnt[d]), 32'(m_cnt[d]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer a vector and return once the capture edge has passed.
    task automatic send(input logic [159:0] v, input logic [16:0] th, input bit early_ready);
        int i;
        scores      = v;
        conf_thresh = th;
        in_valid    = 1'b1;
        out_ready   = early_ready;
        i = 0;
        while (!o_ir[0] && i < 60) begin
            @(posedge clk); #1;
            i++;
        end
        chk("capture_ready", 0, 32'(o_ir[0]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scores   = ~v;
    endtask

    // Count cycles from the capture edge until out_valid rises.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!o_ov[0] && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("valid_latency", 0, 32'(cycles), 32'd11);
    endtask

    // Keep the result pending for hold cycles, then accept it.
    task automatic release_result(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            scores = scores ^ {10{16'h5A5A}};
            chk("held_valid", 0, 32'(o_ov[0]), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt++;
        chk("valid_dropped", 0, 32'(o_ov[0]), 32'd0);
        chk("count_step",    0, 32'(o_cnt[0]), 32'(exp_cnt));
    endtask

    // ---------------- directed tests ----------------
    logic [159:0] v;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        scores      = '0;
        conf_thresh = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready",  0, 32'(o_ir[0]),  32'd1);
        chk("rst_out_valid", 0, 32'(o_ov[0]),  32'd0);
        chk("rst_count",     0, 32'(o_cnt[0]), 32'd0);
        chk("rst_margin",    0, 32'(o_mg[0]),  32'd0);

        // 1) ascending scores
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'((k + 1) * 256);
        send(v, 17'h00050, 1'b0);
        wait_valid(lat);
        chk("t1_best_idx", 0, 32'(o_bi[0]), 32'd9);
        chk("t1_best",     0, 32'(o_bs[0]), 32'h0A00);
        chk("t1_sec_idx",  0, 32'(o_si[0]), 32'd8);
        chk("t1_sec",      0, 32'(o_ss[0]), 32'h0900);
        chk("t1_margin",   0, 32'(o_mg[0]), 32'h00100);
        chk("t1_lowconf",  0, 32'(o_lc[0]), 32'd0);
        release_result(0);

        // 2) all scores equal, with ready held high early
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'h1234;
        send(v, 17'h00050, 1'b1);
        wait_valid(lat);
        chk("t2_hi_best", 0, 32'(o_bi[0]), 32'd9);
        chk("t2_hi_sec",  0, 32'(o_si[0]), 32'd8);
        chk("t2_lo_best", 1, 32'(o_bi[1]), 32'd0);
        chk("t2_lo_sec",  1, 32'(o_si[1]), 32'd1);
        chk("t2_margin",  1, 32'(o_mg[1]), 32'd0);
        chk("t2_lowconf", 0, 32'(o_lc[0]), 32'd1);
        release_result(0);

        // 3) signed: -1 at k=3, most negative elsewhere
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'h8000;
        v[3*16 +: 16] = 16'hFFFF;
        send(v, 17'h00000, 1'b0);
        wait_valid(lat);
        chk("t3_best_idx", 2, 32'(o_bi[2]), 32'd3);
        chk("t3_best",     2, 32'(o_bs[2]), 32'hFFFF);
        chk("t3_sec",      2, 32'(o_ss[2]), 32'h8000);
        chk("t3_margin",   2, 32'(o_mg[2]), 32'h07FFF);
        chk("t3_lo_sec",   1, 32'(o_si[1]), 32'd0);
        release_result(0);

        // 4) out-of-order best on the 5-class instance
        v = '0;
        v[0*16 +: 16] = 16'd5;
        v[1*16 +: 16] = 16'd9;
        v[2*16 +: 16] = 16'd2;
        v[3*16 +: 16] = 16'd9;
        v[4*16 +: 16] = 16'd1;
        send(v, 17'd1, 1'b0);
        wait_valid(lat);
        chk("t4_best_idx", 3, 32'(o_bi[3]), 32'd1);
        chk("t4_best",     3, 32'(o_bs[3]), 32'd9);
        chk("t4_sec_idx",  3, 32'(o_si[3]), 32'd3);
        chk("t4_margin",   3, 32'(o_mg[3]), 32'd0);
        chk("t4_lowconf",  3, 32'(o_lc[3]), 32'd1);
        chk("t4_hi_best",  0, 32'(o_bi[0]), 32'd3);
        chk("t4_hi_sec",   0, 32'(o_si[0]), 32'd1);
        release_result(0);

        // 5) long back-pressure while the inputs keep changing
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'((k * 7919 + 13) & 16'hFFFF);
        send(v, 17'h01000, 1'b0);
        wait_valid(lat);
        chk("t5_in_ready", 0, 32'(o_ir[0]), 32'd0);
        release_result(20);

        // 6) reset in the middle of the scan
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'(16'hF000 - k * 16);
        send(v, 17'h00010, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        chk("t6_in_ready",  0, 32'(o_ir[0]),  32'd1);
        chk("t6_out_valid", 0, 32'(o_ov[0]),  32'd0);
        chk("t6_best_idx",  0, 32'(o_bi[0]),  32'd0);
        chk("t6_best",      0, 32'(o_bs[0]),  32'd0);
        chk("t6_count",     0, 32'(o_cnt[0]), 32'd0);
        for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'((k + 1) * 256);
        send(v, 17'h00050, 1'b0);
        wait_valid(lat);
        chk("t6_fresh_best", 0, 32'(o_bi[0]), 32'd9);
        chk("t6_fresh_mg",   0, 32'(o_mg[0]), 32'h00100);
        release_result(2);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule
